crc32_serial_checker: RTL and testbench
=======================================

# crc32_serial_checker

Receive-side companion to the serial CRC-32 generator. It consumes the generator's serial output stream, MSB-first: data bits followed by 32 CRC bits. It separates the trailing 32 bits as the received CRC, recomputes the CRC over the preceding data bits, and reports match, mismatch or short-frame per frame. It sits directly downstream of the generator on the serial link, or at the far end of a serial channel.

## Interface
- POLY, 32'h8000_0005: Galois feedback taps, bit i set ⇒ feedback XORed into register bit i. Matches the generator: x^32+x^31+x^2+1 form, zero init, no final XOR.
- LEN_W, 16: width of the frame bit counter.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: open a new frame; clears all datapath state.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial data, MSB-first.
- frame_end  in  1  qualified by bit_valid; marks the final bit, which is the last CRC bit.
- busy  out  1  high in RECV.
- done  out  1  one-cycle pulse when a result is valid.
- crc_ok  out  1  frame length ≥ 33 and calc_crc == rx_crc.
- crc_err  out  1  complement of crc_ok, valid with done.
- len_err  out  1  frame shorter than 33 bits.
- rx_crc  out  32  last 32 bits received, first received bit in [31].
- calc_crc  out  32  CRC computed over the data portion.
- frame_len  out  LEN_W  total bits in frame, saturating at all-ones.

## Operation
- States: IDLE, RECV, DONE.
  - IDLE→RECV on start.
  - RECV→DONE on bit_valid & frame_end.
  - RECV→RECV on start: abort and restart, no done.
  - DONE→IDLE unconditionally, or DONE→RECV if start.
- On start accepted:
  - shift register `sh`, `lfsr` and the counter clear to 0.
  - Result outputs (crc_ok, crc_err, len_err, rx_crc, calc_crc, frame_len) clear to 0.
- RECV, each bit_valid cycle:
  - `sh <= {sh[30:0], bit_in}`.
  - Counter increments, saturating.
  - If the count before increment is ≥ 32, the evicted bit e = sh[31] feeds the LFSR:
    - fb = lfsr[31] ^ e.
    - `lfsr <= {lfsr[30:0],1'b0} ^ (fb ? POLY : 0)`.
- bit_valid low: no state change. Gaps of any length are legal.
- frame_end without bit_valid is ignored.
- Bits, including bit_valid, are ignored outside RECV.
- Entering DONE registers results:
  - rx_crc = sh, calc_crc = lfsr, frame_len = count.
  - len_err = (count < 33).
  - crc_ok = !len_err & (sh == lfsr), crc_err = !crc_ok.
- Results hold until the next accepted start or rst.
- start together with frame_end in RECV: frame_end wins and the frame completes; start is ignored.
- start in DONE is accepted, so back-to-back frames are allowed.

## Timing
- Reset values: state IDLE, busy/done/crc_ok/crc_err/len_err = 0, rx_crc/calc_crc/frame_len = 0.
- rst mid-frame discards the frame with no done. The checker is ready for start the cycle after rst deasserts.
- Latency: the edge sampling the last bit moves the state to DONE. done and the results are visible in the following cycle, one cycle after the last bit.
- busy drops in the same cycle done rises.
- Throughput: one bit per clock. Minimum frame period is length + 1 cycles, plus the start cycle.
- Counter saturates at 2^LEN_W−1. Comparison semantics are unaffected; only frame_len is clamped.

## Structure
- Package crc_pkg:
  - CRC_W = 32.
  - POLY default 32'h8000_0005.
  - MIN_FRAME = 33.
  - State enum {IDLE, RECV, DONE}.
- Sub-module crc_serial_lfsr:
  - Ports: clk, rst, clr, en, din, crc[31:0].
  - Parameterised by POLY.
  - Reusable by the generator side.
- The top level holds the FSM, the 32-bit delay shift register, the counter and the result registers.

## Test plan
- Frame "1" + 0x8000_0005 (33 bits, MSB-first) → done 1 cycle after the last bit, crc_ok=1, rx_crc=calc_crc=0x8000_0005, frame_len=33.
- Same frame with the final bit flipped (rx 0x8000_0004) → crc_err=1, len_err=0, calc_crc=0x8000_0005.
- 8 zero data bits + 32 zero CRC bits, with bit_valid deasserted every other cycle → crc_ok=1, calc_crc=0, frame_len=40.
- 20-bit frame → len_err=1, crc_err=1, crc_ok=0.
- start reasserted mid-frame after 10 bits, then a valid 33-bit frame → exactly one done, crc_ok=1, frame_len=33.
- rst asserted mid-frame → all outputs 0, no done. Then frame_end together with start in RECV → frame completes and start is ignored (IDLE after DONE).

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, FSM state type and a one-bit Galois LFSR step used
// by both the serial generator and checker.
package crc_pkg;

  localparam int CRC_W = 32;
  localparam logic [CRC_W-1:0] POLY_DEFAULT = 32'h8000_0005;
  localparam int MIN_FRAME = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Advance the MSB-first Galois register by one input bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic             d,
                                                input logic [CRC_W-1:0] poly);
    logic fb;
    fb = c[CRC_W-1] ^ d;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// Bit-serial CRC register: zero init, no final XOR, one bit per enabled cycle.
module crc_serial_lfsr
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc_step(crc, din, POLY);
    end
  end

endmodule

// File: rtl/crc32_serial_checker.sv
// Receive-side CRC-32 checker: the last 32 bits of a frame are the received CRC,
// everything before them is fed (delayed by 32 bits) into the CRC register.
module crc32_serial_checker
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY  = POLY_DEFAULT,
  parameter int          LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_end,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [31:0]      rx_crc,
  output logic [31:0]      calc_crc,
  output logic [LEN_W-1:0] frame_len
);

  state_t             state_reg, state_next;
  logic [CRC_W-1:0]   sh_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic [CRC_W-1:0]   lfsr_crc;

  logic               bit_acc, last_bit, start_acc, feed;
  logic [CRC_W-1:0]   sh_next, lfsr_next;
  logic [LEN_W-1:0]   cnt_next;
  logic               len_err_next;

  // A start coinciding with the closing bit is dropped so the frame completes.
  assign bit_acc   = (state_reg == RECV) && bit_valid;
  assign last_bit  = bit_acc && frame_end;
  assign start_acc = start && !last_bit;
  assign feed      = bit_acc && !start_acc && (cnt_reg >= LEN_W'(CRC_W));

  assign sh_next   = {sh_reg[CRC_W-2:0], bit_in};
  assign cnt_next  = (&cnt_reg) ? cnt_reg : cnt_reg + LEN_W'(1);
  // Value the CRC register will hold after this edge, needed to register results.
  assign lfsr_next = feed ? crc_step(lfsr_crc, sh_reg[CRC_W-1], POLY) : lfsr_crc;
  assign len_err_next = cnt_next < LEN_W'(MIN_FRAME);

  crc_serial_lfsr #(
    .POLY(POLY)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (feed),
    .din (sh_reg[CRC_W-1]),
    .crc (lfsr_crc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RECV;
      RECV:    if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RECV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      rx_crc    <= '0;
      calc_crc  <= '0;
      frame_len <= '0;
    end else begin
      state_reg <= state_next;
      if (start_acc) begin
        sh_reg    <= '0;
        cnt_reg   <= '0;
        crc_ok    <= 1'b0;
        crc_err   <= 1'b0;
        len_err   <= 1'b0;
        rx_crc    <= '0;
        calc_crc  <= '0;
        frame_len <= '0;
      end else if (bit_acc) begin
        sh_reg  <= sh_next;
        cnt_reg <= cnt_next;
      end
      if (last_bit) begin
        rx_crc    <= sh_next;
        calc_crc  <= lfsr_next;
        frame_len <= cnt_next;
        len_err   <= len_err_next;
        crc_ok    <= !len_err_next && (sh_next == lfsr_next);
        crc_err   <= len_err_next || (sh_next != lfsr_next);
      end
    end
  end

  assign busy = (state_reg == RECV);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_crc32_serial_checker.sv
// Randomised bench for crc32_serial_checker against a polynomial-division model.
module tb_crc32_serial_checker;

  localparam logic [31:0] POLY_TB = 32'h8000_0005;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        frame_end = 1'b0;
  logic        busy, done, crc_ok, crc_err, len_err;
  logic [31:0] rx_crc, calc_crc;
  logic [15:0] frame_len;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  crc32_serial_checker #(
    .POLY (32'h8000_0005),
    .LEN_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .frame_end(frame_end),
    .busy     (busy),
    .done     (done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .len_err  (len_err),
    .rx_crc   (rx_crc),
    .calc_crc (calc_crc),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Remainder of data(x)*x^32 divided by x^32 + POLY, by long division.
  function automatic logic [31:0] ref_crc(input bit data[$]);
    bit          dv[$];
    bit   [32:0] g;
    logic [31:0] r;
    g  = {1'b1, POLY_TB};
    dv = data;
    repeat (32) dv.push_back(1'b0);
    for (int i = 0; i < data.size(); i++)
      if (dv[i])
        for (int k = 0; k <= 32; k++) dv[i+k] = dv[i+k] ^ g[32-k];
    r = '0;
    for (int k = 0; k < 32; k++) r = {r[30:0], dv[data.size()+k]};
    return r;
  endfunction

  task automatic run_frame(input bit fr[$], input int gap_mode, input bit start_at_end,
                           input string tag);
    int          n, d0;
    bit          data[$];
    logic [31:0] exp_rx, exp_calc;
    bit          exp_len_err, exp_ok;
    n  = fr.size();
    d0 = done_cnt;
    exp_rx = '0;
    for (int i = (n > 32 ? n - 32 : 0); i < n; i++) exp_rx = {exp_rx[30:0], fr[i]};
    for (int i = 0; i < n - 32; i++) data.push_back(fr[i]);
    exp_calc    = (n >= 33) ? ref_crc(data) : 32'h0;
    exp_len_err = (n < 33);
    exp_ok      = !exp_len_err && (exp_rx == exp_calc);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, ".busy"}, busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        frame_end = 1'($urandom);
        repeat (gap_mode == 1 ? 1 : $urandom_range(1, 3)) tick();
      end
      bit_valid = 1'b1;
      bit_in    = fr[i];
      frame_end = (i == n - 1);
      if (i == n - 1) start = start_at_end;
      tick();
    end
    bit_valid = 1'b0;
    frame_end = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;

    check_eq({tag, ".done"},      done,      1'b1);
    check_eq({tag, ".busy_low"},  busy,      1'b0);
    check_eq({tag, ".crc_ok"},    crc_ok,    exp_ok);
    check_eq({tag, ".crc_err"},   crc_err,   !exp_ok);
    check_eq({tag, ".len_err"},   len_err,   exp_len_err);
    check_eq({tag, ".rx_crc"},    rx_crc,    exp_rx);
    check_eq({tag, ".calc_crc"},  calc_crc,  exp_calc);
    check_eq({tag, ".frame_len"}, frame_len, 16'(n));
    tick();
    check_eq({tag, ".done_pulse"}, done, 1'b0);
    check_eq({tag, ".idle"},       busy, 1'b0);
    check_eq({tag, ".done_cnt"},   done_cnt, d0 + 1);
  endtask

  task automatic partial_frame(input int k);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic append_crc(inout bit fr[$]);
    logic [31:0] c;
    c = ref_crc(fr);
    for (int k = 31; k >= 0; k--) fr.push_back(c[k]);
  endtask

  initial begin
    bit          fr[$];
    logic [31:0] w;
    int          d0, dl, flip;

    repeat (3) tick();
    check_eq("rst.busy",      busy,      1'b0);
    check_eq("rst.done",      done,      1'b0);
    check_eq("rst.crc_ok",    crc_ok,    1'b0);
    check_eq("rst.crc_err",   crc_err,   1'b0);
    check_eq("rst.len_err",   len_err,   1'b0);
    check_eq("rst.rx_crc",    rx_crc,    32'h0);
    check_eq("rst.calc_crc",  calc_crc,  32'h0);
    check_eq("rst.frame_len", frame_len, 16'h0);
    rst = 1'b0;
    tick();

    // "1" followed by its CRC.
    fr = {};
    fr.push_back(1'b1);
    w = 32'h8000_0005;
    for (int k = 31; k >= 0; k--) fr.push_back(w[k]);
    run_frame(fr, 0, 1'b0, "good33");
    check_eq("good33.const_calc", calc_crc, 32'h8000_0005);
    check_eq("good33.const_ok",   crc_ok,   1'b1);

    fr[32] = 1'b0;
    run_frame(fr, 0, 1'b0, "bad33");
    check_eq("bad33.const_rx",   rx_crc,   32'h8000_0004);
    check_eq("bad33.const_calc", calc_crc, 32'h8000_0005);
    check_eq("bad33.const_err",  crc_err,  1'b1);

    fr = {};
    repeat (40) fr.push_back(1'b0);
    run_frame(fr, 1, 1'b0, "zero40_gaps");
    check_eq("zero40.const_len", frame_len, 16'd40);

    fr = {};
    repeat (20) fr.push_back(1'($urandom));
    run_frame(fr, 0, 1'b0, "short20");
    check_eq("short20.const_len_err", len_err, 1'b1);

    d0 = done_cnt;
    partial_frame(10);
    fr = {};
    fr.push_back(1'($urandom));
    append_crc(fr);
    run_frame(fr, 0, 1'b0, "abort_restart");
    check_eq("abort.one_done", done_cnt, d0 + 1);

    d0 = done_cnt;
    partial_frame(15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst.busy",      busy,      1'b0);
    check_eq("midrst.done",      done,      1'b0);
    check_eq("midrst.rx_crc",    rx_crc,    32'h0);
    check_eq("midrst.frame_len", frame_len, 16'h0);
    tick();
    check_eq("midrst.no_done", done_cnt, d0);

    fr = {};
    repeat (12) fr.push_back(1'($urandom));
    append_crc(fr);
    run_frame(fr, 0, 1'b1, "start_with_end");

    for (int t = 0; t < 25; t++) begin
      fr = {};
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 32)) fr.push_back(1'($urandom));
      end else begin
        dl = $urandom_range(1, 80);
        repeat (dl) fr.push_back(1'($urandom));
        append_crc(fr);
        if ($urandom_range(0, 2) == 0) begin
          flip     = $urandom_range(0, fr.size() - 1);
          fr[flip] = !fr[flip];
        end
      end
      run_frame(fr, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
